// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: load/store formatting, req/gnt/rvalid port, MEM/WB register
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.

package riscv_pkg;
  parameter int XLEN = 32;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [2:0] mem_funct3;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data_str;
    logic [4:0]      rd_addr;
    ctrl_t           ctrl;
    logic            valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      rd_addr;
    ctrl_t           ctrl;
    logic            valid_mem_wb;
  } mem_wb_reg_t;
endpackage

module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_reg_t       ex_mem_in,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [4:0]        mem_rd_addr,
  output logic              mem_reg_write,
  output logic              stall_mem,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output mem_wb_reg_t       mem_wb_out
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t          state, state_n;
  logic            is_load, is_store, is_acc, is_byte, is_half, misaligned;
  logic [1:0]      off;
  logic [2:0]      f3;
  logic            timeout, drop_rw, load_done, misalign_n, bus_err_n;
  logic [XLEN-1:0] lane, load_fmt;
  mem_wb_reg_t     wb_n;

  assign mem_alu_result = ex_mem_in.alu_result;
  assign mem_rd_addr    = ex_mem_in.rd_addr;
  assign mem_reg_write  = ex_mem_in.ctrl.reg_write & ex_mem_in.valid_ex_mem & ~ex_mem_in.ctrl.mem_read;

  // A load takes precedence if both read and write are flagged; unknown funct3 falls to word.
  assign off        = ex_mem_in.alu_result[1:0];
  assign f3         = ex_mem_in.ctrl.mem_funct3;
  assign is_load    = ex_mem_in.ctrl.mem_read;
  assign is_store   = ex_mem_in.ctrl.mem_write & ~is_load;
  assign is_acc     = ex_mem_in.valid_ex_mem & (is_load | is_store);
  assign is_byte    = (f3 == 3'd0) | (is_load & (f3 == 3'd4));
  assign is_half    = (f3 == 3'd1) | (is_load & (f3 == 3'd5));
  assign misaligned = is_acc & ((is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00)));

  // Request fields are derived from the held EX/MEM register, so they stay stable while stalled.
  assign dmem_we   = is_store;
  assign dmem_addr = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ex_mem_in.rs2_data_str;
    if (is_byte) begin
      dmem_be    = 4'b0001 << off;
      dmem_wdata = {4{ex_mem_in.rs2_data_str[7:0]}};
    end else if (is_half) begin
      dmem_be    = 4'b0011 << off;
      dmem_wdata = {2{ex_mem_in.rs2_data_str[15:0]}};
    end
  end

  assign lane = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_fmt = dmem_rdata;
    case (f3)
      3'd0:    load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'd4:    load_fmt = {24'd0, lane[7:0]};
      3'd1:    load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'd5:    load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset || (state_n != state)) begin
      wait_cnt <= '0;
    end else if (state != IDLE) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = (state != IDLE) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    dmem_req   = 1'b0;
    stall_mem  = 1'b0;
    drop_rw    = 1'b0;
    load_done  = 1'b0;
    misalign_n = 1'b0;
    bus_err_n  = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (is_acc) begin
            if (misaligned) begin
              drop_rw    = 1'b1;
              misalign_n = 1'b1;
            end else begin
              dmem_req  = 1'b1;
              stall_mem = 1'b1;
              if (!dmem_gnt)     state_n   = WAIT_GNT;
              else if (is_store) stall_mem = 1'b0;
              else               state_n   = WAIT_RSP;
            end
          end
        end
        WAIT_GNT: begin
          if (timeout) begin
            state_n   = IDLE;
            drop_rw   = 1'b1;
            bus_err_n = 1'b1;
          end else begin
            dmem_req  = 1'b1;
            stall_mem = 1'b1;
            if (dmem_gnt) begin
              if (is_store) begin
                stall_mem = 1'b0;
                state_n   = IDLE;
              end else begin
                state_n = WAIT_RSP;
              end
            end
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            load_done = 1'b1;
            state_n   = IDLE;
          end else if (timeout) begin
            state_n   = IDLE;
            drop_rw   = 1'b1;
            bus_err_n = 1'b1;
          end else begin
            stall_mem = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    wb_n                = '0;
    wb_n.read_data      = load_done ? load_fmt : '0;
    wb_n.alu_result     = ex_mem_in.alu_result;
    wb_n.rd_addr        = ex_mem_in.rd_addr;
    wb_n.ctrl           = ex_mem_in.ctrl;
    wb_n.ctrl.reg_write = ex_mem_in.ctrl.reg_write & ~drop_rw;
    wb_n.valid_mem_wb   = ex_mem_in.valid_ex_mem & ~stall_mem;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      mem_wb_out   <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_n;
      mem_wb_out   <= wb_n;
      misalign_err <= misalign_n;
      bus_err      <= bus_err_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction-level model

module tb_mem_stage;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  ex_mem_reg_t     ex_mem_in;
  logic [31:0]     mem_alu_result;
  logic [4:0]      mem_rd_addr;
  logic            mem_reg_write, stall_mem, misalign_err, bus_err;
  logic            dmem_req, dmem_we;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt, dmem_rvalid;
  mem_wb_reg_t     mem_wb_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ex_mem_in(ex_mem_in),
    .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .stall_mem(stall_mem), .misalign_err(misalign_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_wb_out(mem_wb_out)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic rd, input logic [2:0] f3);
    if (f3 == 3'd0 || (rd && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (rd && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] sh, v;
    sh = rdata >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = sh & 32'hFF;
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = sh & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  // Drive one EX/MEM instruction and play the memory side; starts and ends just after a posedge.
  task automatic run_txn(input logic v, input logic rd, input logic wr, input logic regw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input logic [4:0] rda, input int gdly, input int rdly);
    logic acc, mis, gcyc;
    int sz;
    logic [31:0] exp_be, exp_wd;
    ex_mem_in = '0;
    ex_mem_in.valid_ex_mem    = v;
    ex_mem_in.ctrl.mem_read   = rd;
    ex_mem_in.ctrl.mem_write  = wr;
    ex_mem_in.ctrl.reg_write  = regw;
    ex_mem_in.ctrl.mem_funct3 = f3;
    ex_mem_in.alu_result      = addr;
    ex_mem_in.rs2_data_str    = rs2;
    ex_mem_in.rd_addr         = rda;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    acc = v && (rd || wr);
    sz  = acc_size(rd, f3);
    mis = acc && ((addr % sz) != 0);
    exp_be = (sz == 1) ? (32'd1 << (addr % 4)) : (sz == 2) ? (32'd3 << (addr % 4)) : 32'd15;
    exp_wd = (sz == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
             (sz == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;

    if (!acc || mis) begin
      @(negedge clk);
      check("fwd_alu", mem_alu_result, addr);
      check("fwd_rd", mem_rd_addr, rda);
      check("fwd_rw", mem_reg_write, v && regw && !rd);
      check("req_none", dmem_req, 0);
      check("stall_none", stall_mem, 0);
      @(posedge clk); #1;
      check("wb_valid", mem_wb_out.valid_mem_wb, v);
      if (v) begin
        check("wb_rw", mem_wb_out.ctrl.reg_write, regw && !mis);
        check("wb_rd", mem_wb_out.rd_addr, rda);
        check("wb_alu", mem_wb_out.alu_result, addr);
      end
      check("misalign_err", misalign_err, mis);
      return;
    end

    for (int i = 0; i <= gdly; i++) begin
      gcyc        = (i == gdly);
      dmem_gnt    = gcyc;
      dmem_rvalid = gcyc ? 1'b0 : 1'($urandom_range(0, 1));
      dmem_rdata  = $urandom;
      @(negedge clk);
      if (i == 0) begin
        check("fwd_alu", mem_alu_result, addr);
        check("fwd_rw", mem_reg_write, regw && !rd);
      end
      check("req_on", dmem_req, 1);
      check("req_we", dmem_we, wr);
      check("req_addr", dmem_addr, addr & 32'hFFFFFFFC);
      if (wr) begin
        check("req_be", dmem_be, exp_be);
        check("req_wdata", dmem_wdata, exp_wd);
      end
      check("stall_req", stall_mem, !(gcyc && wr));
      @(posedge clk); #1;
      if (!(gcyc && wr)) check("wb_bubble", mem_wb_out.valid_mem_wb, 0);
    end
    dmem_gnt = 1'b0;
    if (wr) begin
      check("st_valid", mem_wb_out.valid_mem_wb, 1);
      check("st_rw", mem_wb_out.ctrl.reg_write, regw);
      return;
    end

    for (int j = 0; j <= rdly; j++) begin
      dmem_rvalid = (j == rdly);
      dmem_rdata  = (j == rdly) ? rdata : $urandom;
      @(negedge clk);
      check("rsp_req", dmem_req, 0);
      check("rsp_stall", stall_mem, j != rdly);
      @(posedge clk); #1;
      if (j != rdly) check("rsp_bubble", mem_wb_out.valid_mem_wb, 0);
    end
    dmem_rvalid = 1'b0;
    check("ld_valid", mem_wb_out.valid_mem_wb, 1);
    check("ld_data", mem_wb_out.read_data, load_val(f3, addr, rdata));
    check("ld_rw", mem_wb_out.ctrl.reg_write, regw);
    check("ld_rd", mem_wb_out.rd_addr, rda);
  endtask

  initial begin
    int kind, stalled;
    logic [2:0] f3;
    logic [31:0] addr;

    reset = 1'b0; ex_mem_in = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb", mem_wb_out, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_bus_err", bus_err, 0);
    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_mem, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_txn(1, 1, 0, 1, 3'd2, 32'h100, 0, 32'hDEADBEEF, 5'd1, 0, 0);
    run_txn(1, 1, 0, 1, 3'd0, 32'h103, 0, 32'h80112233, 5'd2, 1, 1);
    run_txn(1, 1, 0, 1, 3'd4, 32'h103, 0, 32'h80112233, 5'd2, 0, 2);
    run_txn(1, 0, 1, 0, 3'd1, 32'h202, 32'h0000ABCD, 0, 5'd0, 0, 0);
    run_txn(1, 1, 0, 1, 3'd2, 32'h300, 0, 32'h12345678, 5'd3, 3, 2);
    run_txn(1, 1, 0, 1, 3'd2, 32'h102, 0, 0, 5'd4, 0, 0);
    run_txn(1, 0, 0, 1, 3'd0, 32'h55, 0, 0, 5'd7, 0, 0);

    // Reset while waiting for a load response; a late rvalid must be ignored.
    ex_mem_in = '0;
    ex_mem_in.valid_ex_mem = 1'b1; ex_mem_in.ctrl.mem_read = 1'b1;
    ex_mem_in.ctrl.reg_write = 1'b1; ex_mem_in.ctrl.mem_funct3 = 3'd2;
    ex_mem_in.alu_result = 32'h400;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("wrsp_stall", stall_mem, 1);
    @(posedge clk); #1;
    reset = 1'b0; ex_mem_in = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_req", dmem_req, 0);
    check("midrst_stall", stall_mem, 0);
    check("midrst_wb", mem_wb_out, 0);
    reset = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    check("late_rvalid_wb", mem_wb_out.valid_mem_wb, 0);
    check("late_rvalid_data", mem_wb_out.read_data, 0);

`ifdef MEM_TIMEOUT_EN
    ex_mem_in = '0;
    ex_mem_in.valid_ex_mem = 1'b1; ex_mem_in.ctrl.mem_read = 1'b1;
    ex_mem_in.ctrl.reg_write = 1'b1; ex_mem_in.ctrl.mem_funct3 = 3'd2;
    ex_mem_in.alu_result = 32'h500;
    stalled = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall_mem) break;
      stalled++;
      @(posedge clk); #1;
    end
    check("to_stall_cycles", stalled, 16);
    check("to_req_drop", dmem_req, 0);
    @(posedge clk); #1;
    ex_mem_in = '0;
    check("to_bus_err", bus_err, 1);
    check("to_wb_valid", mem_wb_out.valid_mem_wb, 1);
    check("to_wb_rw", mem_wb_out.ctrl.reg_write, 0);
    @(posedge clk); #1;
    check("to_bus_err_pulse", bus_err, 0);
`endif

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0)
        addr = addr - (addr % acc_size(kind == 1, f3));
      run_txn(($urandom_range(0, 7) != 0), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
              f3, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("end_bus_err", bus_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
